// File: rtl/alu_pkg.sv
// Shared constants for the ALU control / multiply-divide block.
// Holds the ALU control codes, aluop encodings, M-extension funct3 codes,
// funct7 constants, the handshake FSM state encoding and small decode helpers.
package alu_pkg;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SLL  = 4'b0011;
    localparam logic [3:0] ALU_SLT  = 4'b0100;
    localparam logic [3:0] ALU_SLTU = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_XOR  = 4'b0111;
    localparam logic [3:0] ALU_SRL  = 4'b1000;
    localparam logic [3:0] ALU_BLT  = 4'b1001;
    localparam logic [3:0] ALU_SRA  = 4'b1010;
    localparam logic [3:0] ALU_BLTU = 4'b1100;
    localparam logic [3:0] ALU_ILL  = 4'b1111;

    localparam logic [1:0] AOP_MEM = 2'b00;
    localparam logic [1:0] AOP_BR  = 2'b01;
    localparam logic [1:0] AOP_R   = 2'b10;
    localparam logic [1:0] AOP_I   = 2'b11;

    localparam logic [2:0] M_MUL    = 3'b000;
    localparam logic [2:0] M_MULH   = 3'b001;
    localparam logic [2:0] M_MULHSU = 3'b010;
    localparam logic [2:0] M_MULHU  = 3'b011;
    localparam logic [2:0] M_DIV    = 3'b100;
    localparam logic [2:0] M_DIVU   = 3'b101;
    localparam logic [2:0] M_REM    = 3'b110;
    localparam logic [2:0] M_REMU   = 3'b111;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_DONE = 2'b10
    } md_state_e;

    // Base integer op selected by funct3 alone (shared by R-type and I-type).
    function automatic logic [3:0] base_op(input logic [2:0] f3);
        logic [3:0] code;
        case (f3)
            3'b000:  code = ALU_ADD;
            3'b001:  code = ALU_SLL;
            3'b010:  code = ALU_SLT;
            3'b011:  code = ALU_SLTU;
            3'b100:  code = ALU_XOR;
            3'b101:  code = ALU_SRL;
            3'b110:  code = ALU_OR;
            3'b111:  code = ALU_AND;
            default: code = ALU_ILL;
        endcase
        return code;
    endfunction

    // Operand A is treated as two's complement (MUL low half is sign-agnostic).
    function automatic logic op_signed_a(input logic [2:0] op);
        return (op == M_MUL) || (op == M_MULH) || (op == M_MULHSU) ||
               (op == M_DIV) || (op == M_REM);
    endfunction

    // Operand B is treated as two's complement.
    function automatic logic op_signed_b(input logic [2:0] op);
        return (op == M_MUL) || (op == M_MULH) || (op == M_DIV) || (op == M_REM);
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative multiply/divide datapath.
// Operands are latched as magnitudes plus sign flags on i_start; every cycle
// while the counter is non-zero UNROLL result bits are produced (shift-add
// multiply, restoring divide). o_res_nxt is the sign-corrected, hi/lo selected
// result that the accumulator will hold after this cycle's step, so the
// controller can register it on the final step. Divide-by-zero and signed
// overflow are recognised combinationally from the raw inputs (o_special).
// Ports: clk, rst_n, i_start, i_abort, i_op (funct3), i_a, i_b,
//        o_special, o_special_res, o_last (final step this cycle), o_res_nxt.
module muldiv_iter
    import alu_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int UNROLL = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_start,
    input  logic            i_abort,
    input  logic [2:0]      i_op,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    output logic            o_special,
    output logic [XLEN-1:0] o_special_res,
    output logic            o_last,
    output logic [XLEN-1:0] o_res_nxt
);
    localparam int STEPS = XLEN / UNROLL;
    localparam int CW    = $clog2(STEPS + 1);
    localparam logic [CW-1:0]   CNT_LOAD = CW'(STEPS);
    localparam logic [XLEN-1:0] SMIN     = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ONES     = {XLEN{1'b1}};

    logic [CW-1:0]     r_cnt;
    logic [2:0]        r_op;
    logic [XLEN-1:0]   r_ma;
    logic [XLEN-1:0]   r_mb;
    logic              r_neg_main;
    logic              r_neg_rem;
    logic [2*XLEN-1:0] r_acc;

    logic              w_a_sgn;
    logic              w_b_sgn;
    logic [XLEN-1:0]   w_ma;
    logic [XLEN-1:0]   w_mb;
    logic              w_dz;
    logic              w_ovf;
    logic [XLEN-1:0]   w_hi;
    logic [XLEN-1:0]   w_lo;
    logic [XLEN:0]     w_sum;
    logic [XLEN:0]     w_trial;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_quot;
    logic [XLEN-1:0]   w_rem;

    assign w_a_sgn = op_signed_a(i_op) & i_a[XLEN-1];
    assign w_b_sgn = op_signed_b(i_op) & i_b[XLEN-1];
    assign w_ma    = w_a_sgn ? -i_a : i_a;
    assign w_mb    = w_b_sgn ? -i_b : i_b;
    assign o_last  = (r_cnt == CW'(1));

    // Early-out cases: divide by zero, and the one signed quotient that overflows.
    always_comb begin
        w_dz          = i_op[2] && (i_b == {XLEN{1'b0}});
        w_ovf         = ((i_op == M_DIV) || (i_op == M_REM)) && (i_a == SMIN) && (i_b == ONES);
        o_special     = w_dz | w_ovf;
        o_special_res = {XLEN{1'b0}};
        if (w_dz) begin
            o_special_res = i_op[1] ? i_a : ONES;
        end else if (w_ovf) begin
            o_special_res = i_op[1] ? {XLEN{1'b0}} : SMIN;
        end else begin
            o_special_res = {XLEN{1'b0}};
        end
    end

    // UNROLL iterations of shift-add (multiply) or restoring subtract (divide).
    always_comb begin
        w_hi    = r_acc[2*XLEN-1:XLEN];
        w_lo    = r_acc[XLEN-1:0];
        w_sum   = {(XLEN+1){1'b0}};
        w_trial = {(XLEN+1){1'b0}};
        for (int u = 0; u < UNROLL; u++) begin
            if (r_op[2] == 1'b0) begin
                // {hi,lo} holds partial product above the unconsumed multiplier bits.
                w_sum = {1'b0, w_hi} + (w_lo[0] ? {1'b0, r_ma} : {(XLEN+1){1'b0}});
                w_lo  = {w_sum[0], w_lo[XLEN-1:1]};
                w_hi  = w_sum[XLEN:1];
            end else begin
                // hi is the partial remainder, lo shifts dividend out / quotient in.
                w_trial = {w_hi, w_lo[XLEN-1]};
                w_lo    = {w_lo[XLEN-2:0], 1'b0};
                if (w_trial >= {1'b0, r_mb}) begin
                    w_trial = w_trial - {1'b0, r_mb};
                    w_lo[0] = 1'b1;
                end else begin
                    w_lo[0] = 1'b0;
                end
                w_hi = w_trial[XLEN-1:0];
            end
        end
    end

    assign w_prod = r_neg_main ? -{w_hi, w_lo} : {w_hi, w_lo};
    assign w_quot = r_neg_main ? -w_lo : w_lo;
    assign w_rem  = r_neg_rem  ? -w_hi : w_hi;

    // Final result selection from the post-step accumulator.
    always_comb begin
        case (r_op)
            M_MUL:                     o_res_nxt = w_prod[XLEN-1:0];
            M_MULH, M_MULHSU, M_MULHU: o_res_nxt = w_prod[2*XLEN-1:XLEN];
            M_DIV, M_DIVU:             o_res_nxt = w_quot;
            M_REM, M_REMU:             o_res_nxt = w_rem;
            default:                   o_res_nxt = {XLEN{1'b0}};
        endcase
    end

    // Operand latch, iteration counter and accumulator.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= {CW{1'b0}};
            r_op       <= 3'b000;
            r_ma       <= {XLEN{1'b0}};
            r_mb       <= {XLEN{1'b0}};
            r_neg_main <= 1'b0;
            r_neg_rem  <= 1'b0;
            r_acc      <= {(2*XLEN){1'b0}};
        end else if (i_abort) begin
            r_cnt <= {CW{1'b0}};
        end else if (i_start) begin
            r_cnt      <= CNT_LOAD;
            r_op       <= i_op;
            r_ma       <= w_ma;
            r_mb       <= w_mb;
            r_neg_main <= w_a_sgn ^ w_b_sgn;
            r_neg_rem  <= w_a_sgn;
            r_acc      <= {{XLEN{1'b0}}, (i_op[2] ? w_ma : w_mb)};
        end else if (r_cnt != {CW{1'b0}}) begin
            r_cnt <= r_cnt - CW'(1);
            r_acc <= {w_hi, w_lo};
        end else begin
            r_cnt <= r_cnt;
        end
    end

endmodule

// File: rtl/alu_muldiv_ctrl.sv
// ALU control decode with an iterative RV32M/RV64M multiply/divide engine.
// Base/branch ops decode combinationally to a 4-bit ALU code; M ops are run
// by muldiv_iter under an IDLE/CALC/DONE handshake that stalls the core.
// Ports: clk, rst_n, valid_i, aluop_i, funct7_i, funct3_i, rs1_i, rs2_i,
//        flush_i (inputs); alu_ctrl_o, illegal_o, md_sel_o (combinational),
//        stall_o, md_done_o, md_result_o (handshake / registered result).
module alu_muldiv_ctrl
    import alu_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int UNROLL = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            valid_i,
    input  logic [1:0]      aluop_i,
    input  logic [6:0]      funct7_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic            flush_i,
    output logic [3:0]      alu_ctrl_o,
    output logic            illegal_o,
    output logic            md_sel_o,
    output logic            stall_o,
    output logic            md_done_o,
    output logic [XLEN-1:0] md_result_o
);
    md_state_e       r_state;
    md_state_e       w_state_nxt;
    logic            r_done;
    logic [XLEN-1:0] r_result;
    logic            w_accept;
    logic            w_load_special;
    logic            w_load_calc;
    logic            w_special;
    logic [XLEN-1:0] w_special_res;
    logic            w_last;
    logic [XLEN-1:0] w_res_nxt;

    // Instruction decode; anything unrecognised falls to ALU_ILL.
    always_comb begin
        alu_ctrl_o = ALU_ILL;
        illegal_o  = 1'b1;
        md_sel_o   = 1'b0;
        case (aluop_i)
            AOP_MEM: begin
                alu_ctrl_o = ALU_ADD;
                illegal_o  = 1'b0;
            end
            AOP_BR: begin
                illegal_o = 1'b0;
                case (funct3_i)
                    3'b000, 3'b001: alu_ctrl_o = ALU_SUB;
                    3'b100, 3'b101: alu_ctrl_o = ALU_BLT;
                    3'b110, 3'b111: alu_ctrl_o = ALU_BLTU;
                    default: begin
                        alu_ctrl_o = ALU_ILL;
                        illegal_o  = 1'b1;
                    end
                endcase
            end
            AOP_R: begin
                if (funct7_i == F7_BASE) begin
                    alu_ctrl_o = base_op(funct3_i);
                    illegal_o  = 1'b0;
                end else if (funct7_i == F7_ALT && funct3_i == 3'b000) begin
                    alu_ctrl_o = ALU_SUB;
                    illegal_o  = 1'b0;
                end else if (funct7_i == F7_ALT && funct3_i == 3'b101) begin
                    alu_ctrl_o = ALU_SRA;
                    illegal_o  = 1'b0;
                end else if (funct7_i == F7_MULDIV) begin
                    // ALU result is unused for M ops; keep a benign code.
                    alu_ctrl_o = ALU_ADD;
                    illegal_o  = 1'b0;
                    md_sel_o   = 1'b1;
                end else begin
                    alu_ctrl_o = ALU_ILL;
                    illegal_o  = 1'b1;
                end
            end
            AOP_I: begin
                // Only the shift immediates carry meaning in funct7.
                if (funct3_i == 3'b001 && funct7_i == F7_BASE) begin
                    alu_ctrl_o = ALU_SLL;
                    illegal_o  = 1'b0;
                end else if (funct3_i == 3'b101 && funct7_i == F7_BASE) begin
                    alu_ctrl_o = ALU_SRL;
                    illegal_o  = 1'b0;
                end else if (funct3_i == 3'b101 && funct7_i == F7_ALT) begin
                    alu_ctrl_o = ALU_SRA;
                    illegal_o  = 1'b0;
                end else if (funct3_i != 3'b001 && funct3_i != 3'b101) begin
                    alu_ctrl_o = base_op(funct3_i);
                    illegal_o  = 1'b0;
                end else begin
                    alu_ctrl_o = ALU_ILL;
                    illegal_o  = 1'b1;
                end
            end
            default: begin
                alu_ctrl_o = ALU_ILL;
                illegal_o  = 1'b1;
            end
        endcase
    end

    // Next-state logic; flush overrides everything including a same-cycle accept.
    always_comb begin
        w_state_nxt    = r_state;
        w_accept       = 1'b0;
        w_load_special = 1'b0;
        w_load_calc    = 1'b0;
        if (flush_i) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (valid_i && md_sel_o) begin
                        w_accept       = 1'b1;
                        w_load_special = w_special;
                        w_state_nxt    = w_special ? ST_DONE : ST_CALC;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                ST_CALC: begin
                    if (w_last) begin
                        w_load_calc = 1'b1;
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_state_nxt = ST_CALC;
                    end
                end
                ST_DONE: w_state_nxt = ST_IDLE;
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // State, done pulse and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_done   <= 1'b0;
            r_result <= {XLEN{1'b0}};
        end else begin
            r_state <= w_state_nxt;
            r_done  <= (w_state_nxt == ST_DONE);
            if (w_load_special) begin
                r_result <= w_special_res;
            end else if (w_load_calc) begin
                r_result <= w_res_nxt;
            end else begin
                r_result <= r_result;
            end
        end
    end

    assign stall_o     = ((r_state == ST_IDLE) && valid_i && md_sel_o) || (r_state == ST_CALC);
    assign md_done_o   = r_done;
    assign md_result_o = r_result;

    muldiv_iter #(
        .XLEN   (XLEN),
        .UNROLL (UNROLL)
    ) u_iter (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_start       (w_accept & ~w_special),
        .i_abort       (flush_i),
        .i_op          (funct3_i),
        .i_a           (rs1_i),
        .i_b           (rs2_i),
        .o_special     (w_special),
        .o_special_res (w_special_res),
        .o_last        (w_last),
        .o_res_nxt     (w_res_nxt)
    );

endmodule

// File: tb/tb_alu_muldiv_ctrl.sv
// Directed self-checking bench for alu_muldiv_ctrl (XLEN=32, UNROLL=1).
module tb_alu_muldiv_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_i;
    logic [1:0]  aluop_i;
    logic [6:0]  funct7_i;
    logic [2:0]  funct3_i;
    logic [31:0] rs1_i;
    logic [31:0] rs2_i;
    logic        flush_i;
    logic [3:0]  alu_ctrl_o;
    logic        illegal_o;
    logic        md_sel_o;
    logic        stall_o;
    logic        md_done_o;
    logic [31:0] md_result_o;

    int n_checks = 0;
    int n_fail   = 0;

    alu_muldiv_ctrl #(.XLEN(32), .UNROLL(1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .valid_i     (valid_i),
        .aluop_i     (aluop_i),
        .funct7_i    (funct7_i),
        .funct3_i    (funct3_i),
        .rs1_i       (rs1_i),
        .rs2_i       (rs2_i),
        .flush_i     (flush_i),
        .alu_ctrl_o  (alu_ctrl_o),
        .illegal_o   (illegal_o),
        .md_sel_o    (md_sel_o),
        .stall_o     (stall_o),
        .md_done_o   (md_done_o),
        .md_result_o (md_result_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic dec(input string tag, input logic [1:0] op, input logic [6:0] f7,
                       input logic [2:0] f3, input logic [3:0] exp_ctrl,
                       input logic exp_ill, input logic exp_md);
        @(negedge clk);
        aluop_i  = op;
        funct7_i = f7;
        funct3_i = f3;
        #1;
        check({tag, "/ctrl"}, 64'(alu_ctrl_o), 64'(exp_ctrl));
        check({tag, "/ill"},  64'(illegal_o),  64'(exp_ill));
        check({tag, "/md"},   64'(md_sel_o),   64'(exp_md));
    endtask

    // Issue one M op, hold fields while stalled, measure latency and stall length.
    task automatic run_md(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res, input int exp_cyc);
        int n;
        int stalls;
        @(negedge clk);
        valid_i  = 1'b1;
        aluop_i  = 2'b10;
        funct7_i = 7'b0000001;
        funct3_i = f3;
        rs1_i    = a;
        rs2_i    = b;
        #1;
        n = 0;
        stalls = 0;
        while (md_done_o !== 1'b1 && n < 200) begin
            if (stall_o === 1'b1) stalls++;
            @(negedge clk);
            #1;
            n++;
        end
        check({tag, "/lat"},   64'(n),           64'(exp_cyc));
        check({tag, "/stall"}, 64'(stalls),      64'(exp_cyc));
        check({tag, "/nostall_done"}, 64'(stall_o), 64'd0);
        check({tag, "/res"},   64'(md_result_o), 64'(exp_res));
        valid_i = 1'b0;
    endtask

    initial begin
        int n;
        logic done_seen;
        rst_n    = 1'b0;
        valid_i  = 1'b0;
        flush_i  = 1'b0;
        aluop_i  = 2'b00;
        funct7_i = 7'b0000000;
        funct3_i = 3'b000;
        rs1_i    = 32'd0;
        rs2_i    = 32'd0;

        // Reset state
        @(negedge clk);
        #1;
        check("rst/done",   64'(md_done_o),   64'd0);
        check("rst/result", 64'(md_result_o), 64'd0);
        check("rst/stall",  64'(stall_o),     64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Decode
        dec("r_sra",   2'b10, 7'b0100000, 3'b101, 4'b1010, 1'b0, 1'b0);
        dec("addi_f7", 2'b11, 7'b0100000, 3'b000, 4'b0010, 1'b0, 1'b0);
        dec("br_010",  2'b01, 7'b0000000, 3'b010, 4'b1111, 1'b1, 1'b0);
        dec("r_f7bad", 2'b10, 7'b0000010, 3'b000, 4'b1111, 1'b1, 1'b0);
        dec("ldst",    2'b00, 7'b1111111, 3'b111, 4'b0010, 1'b0, 1'b0);
        dec("beq",     2'b01, 7'b0000000, 3'b000, 4'b0110, 1'b0, 1'b0);
        dec("bltu",    2'b01, 7'b0000000, 3'b110, 4'b1100, 1'b0, 1'b0);
        dec("bge",     2'b01, 7'b0000000, 3'b101, 4'b1001, 1'b0, 1'b0);
        dec("slt",     2'b10, 7'b0000000, 3'b010, 4'b0100, 1'b0, 1'b0);
        dec("r_sub",   2'b10, 7'b0100000, 3'b000, 4'b0110, 1'b0, 1'b0);
        dec("r_alt_or",2'b10, 7'b0100000, 3'b110, 4'b1111, 1'b1, 1'b0);
        dec("srai",    2'b11, 7'b0100000, 3'b101, 4'b1010, 1'b0, 1'b0);
        dec("srai_bad",2'b11, 7'b0000001, 3'b101, 4'b1111, 1'b1, 1'b0);
        dec("andi",    2'b11, 7'b1010101, 3'b111, 4'b0000, 1'b0, 1'b0);
        dec("mul_sel", 2'b10, 7'b0000001, 3'b000, 4'b0010, 1'b0, 1'b1);

        // Multiply
        run_md("mul",    3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33);
        run_md("mulhu",  3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
        run_md("mulh",   3'b001, 32'h40000000, 32'd4,        32'h00000001, 33);
        run_md("mulhsu", 3'b010, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF, 33);

        // Divide, including the early-out cases
        run_md("div",      3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33);
        run_md("rem",      3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33);
        run_md("divu_dz",  3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 1);
        run_md("rem_ovf",  3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1);
        run_md("div_ovf",  3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
        run_md("remu_dz",  3'b111, 32'd9,        32'd0,        32'd9,        1);
        run_md("remu",     3'b111, 32'd100,      32'd7,        32'd2,        33);

        // Flush during CALC cycle 10
        @(negedge clk);
        valid_i  = 1'b1;
        aluop_i  = 2'b10;
        funct7_i = 7'b0000001;
        funct3_i = 3'b100;
        rs1_i    = 32'd1000;
        rs2_i    = 32'd3;
        repeat (10) @(negedge clk);
        #1;
        check("flush/calc_stall", 64'(stall_o), 64'd1);
        flush_i = 1'b1;
        valid_i = 1'b0;
        @(negedge clk);
        flush_i = 1'b0;
        #1;
        check("flush/idle_stall", 64'(stall_o),     64'd0);
        check("flush/no_done",    64'(md_done_o),   64'd0);
        check("flush/result_kept",64'(md_result_o), 64'd2);
        done_seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            #1;
            if (md_done_o === 1'b1) done_seen = 1'b1;
        end
        check("flush/no_late_done", 64'(done_seen), 64'd0);
        run_md("divu_after_flush", 3'b101, 32'd100, 32'd7, 32'd14, 33);

        // Flush beats a same-cycle accept
        @(negedge clk);
        valid_i  = 1'b1;
        funct3_i = 3'b000;
        rs1_i    = 32'd3;
        rs2_i    = 32'd3;
        flush_i  = 1'b1;
        #1;
        check("flush_acc/idle_stall", 64'(stall_o), 64'd1);
        @(negedge clk);
        flush_i = 1'b0;
        valid_i = 1'b0;
        #1;
        check("flush_acc/not_calc", 64'(stall_o), 64'd0);

        // Asynchronous reset at CALC cycle 5
        @(negedge clk);
        valid_i  = 1'b1;
        funct3_i = 3'b000;
        rs1_i    = 32'd5;
        rs2_i    = 32'd6;
        repeat (5) @(negedge clk);
        #1;
        check("rstmid/calc_stall", 64'(stall_o), 64'd1);
        rst_n   = 1'b0;
        valid_i = 1'b0;
        #1;
        check("rstmid/result", 64'(md_result_o), 64'd0);
        check("rstmid/done",   64'(md_done_o),   64'd0);
        check("rstmid/stall",  64'(stall_o),     64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check("rstmid/idle", 64'(stall_o), 64'd0);

        // Back-to-back MULs: second op presented during the first DONE
        @(negedge clk);
        valid_i  = 1'b1;
        funct3_i = 3'b000;
        rs1_i    = 32'd7;
        rs2_i    = 32'hFFFFFFFD;
        #1;
        n = 0;
        while (md_done_o !== 1'b1 && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("b2b/first_lat", 64'(n),           64'd33);
        check("b2b/first_res", 64'(md_result_o), 64'hFFFFFFEB);
        rs1_i = 32'd6;
        rs2_i = 32'd9;
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (md_done_o !== 1'b1 && n < 200);
        check("b2b/gap",        64'(n),           64'd34);
        check("b2b/second_res", 64'(md_result_o), 64'd54);
        valid_i = 1'b0;
        @(negedge clk);
        #1;
        check("b2b/pulse_one_cycle", 64'(md_done_o), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
